// File: rtl/mem_wb_hilo_pkg.sv
// mem_wb_hilo_pkg
//   Shared constants and helpers for the MEM->WB register and its HI/LO owner.
//   Constants mirror the legacy define.v names (RegBus, NOPRegAddr, RstEnable, ...).
//   Contents:
//     RST_ENABLE / WRITE_ENABLE / WRITE_DISABLE / STOP / NO_STOP  control levels
//     REG_BUS_W / REG_ADDR_BUS_W                                   default bus widths
//     ZERO_WORD / NOP_REG_ADDR                                     reset / bubble values
//     stage_act_e, stage_action()                                  per-edge WB slot action
package mem_wb_hilo_pkg;

    localparam int unsigned REG_BUS_W      = 32;
    localparam int unsigned REG_ADDR_BUS_W = 5;

    localparam logic RST_ENABLE    = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;

    localparam logic [REG_BUS_W-1:0]      ZERO_WORD    = '0;
    localparam logic [REG_ADDR_BUS_W-1:0] NOP_REG_ADDR = '0;

    // What the WB slot does on a non-reset edge.
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_HOLD    = 2'd1,
        ACT_BUBBLE  = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_e;

    // Priority: flush > bubble (MEM stalled, WB free) > hold (both stalled) > advance.
    function automatic stage_act_e stage_action(input logic flush,
                                                input logic stall_mem,
                                                input logic stall_wb);
        stage_act_e act;
        if (flush)
            act = ACT_FLUSH;
        else if (stall_mem == STOP && stall_wb == NO_STOP)
            act = ACT_BUBBLE;
        else if (stall_mem == STOP)
            act = ACT_HOLD;
        else
            act = ACT_ADVANCE;
        return act;
    endfunction

endpackage

// File: rtl/mem_wb_hilo_hilo_reg.sv
// mem_wb_hilo_hilo_reg
//   Architectural HI/LO register pair. Loads both halves when i_we is high.
//   Ports:
//     i_clk        clock (posedge)
//     i_rst        synchronous reset, active-low
//     i_we         commit enable
//     i_hi, i_lo   values to commit
//     o_hi, o_lo   architectural HI / LO
module mem_wb_hilo_hilo_reg
    import mem_wb_hilo_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_hi,
    input  logic [DATA_W-1:0] i_lo,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    always_ff @(posedge i_clk) begin
        if (i_rst == RST_ENABLE) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_we == WRITE_ENABLE) begin
            r_hi <= i_hi;
            r_lo <= i_lo;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/mem_wb_hilo.sv
// mem_wb_hilo
//   MEM->WB pipeline register plus owner of the architectural HI/LO pair.
//   HI/LO commit one cycle after the writing instruction reaches WB, and a
//   retired-instruction counter advances whenever a valid WB instruction leaves.
//   Build option: define HILO_FWD_EN to forward pending HI/LO writes to EX
//   (youngest wins); otherwise EX sees the architectural HI/LO only.
//   Ports:
//     clk, rst                 clock / synchronous active-low reset
//     mem_valid                MEM slot holds a real instruction
//     mem_wd/wreg/wdata        MEM-stage GPR write
//     mem_whilo/hi/lo          MEM-stage HI/LO write
//     stall, flush             pipeline control
//     wb_wd/wreg/wdata/whilo   WB-stage bundle to the regfile
//     hi_o, lo_o               architectural HI / LO
//     ex_hi, ex_lo             HI / LO as seen by EX (combinational)
//     retire_cnt               retired-instruction count (wraps)
module mem_wb_hilo
    import mem_wb_hilo_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned STALL_W   = 6,
    parameter int unsigned STALL_IDX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_valid,
    input  logic [ADDR_W-1:0]  mem_wd,
    input  logic               mem_wreg,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_whilo,
    input  logic [DATA_W-1:0]  mem_hi,
    input  logic [DATA_W-1:0]  mem_lo,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    output logic [ADDR_W-1:0]  wb_wd,
    output logic               wb_wreg,
    output logic [DATA_W-1:0]  wb_wdata,
    output logic               wb_whilo,
    output logic [DATA_W-1:0]  hi_o,
    output logic [DATA_W-1:0]  lo_o,
    output logic [DATA_W-1:0]  ex_hi,
    output logic [DATA_W-1:0]  ex_lo,
    output logic [31:0]        retire_cnt
);

    logic [ADDR_W-1:0] r_wb_wd;
    logic              r_wb_wreg;
    logic [DATA_W-1:0] r_wb_wdata;
    logic              r_wb_whilo;
    logic [DATA_W-1:0] r_wb_hi;
    logic [DATA_W-1:0] r_wb_lo;
    logic              r_wb_valid;
    logic [31:0]       r_retire_cnt;

    logic       w_stall_mem;
    logic       w_stall_wb;
    logic       w_commit;
    logic       w_retire;
    logic       w_unused_stall;
    stage_act_e w_act;

    assign w_stall_mem = stall[STALL_IDX];
    assign w_stall_wb  = stall[STALL_IDX+1];
    assign w_act       = stage_action(flush, w_stall_mem, w_stall_wb);

    // The WB occupant is already past the flush point, so commit and retire
    // depend only on the WB stall bit, never on flush.
    assign w_commit = r_wb_whilo & (w_stall_wb == NO_STOP);
    assign w_retire = r_wb_valid & (w_stall_wb == NO_STOP);

    // Only this stage's two stall bits matter here.
    assign w_unused_stall = ^stall;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_wb_wd      <= '0;
            r_wb_wreg    <= WRITE_DISABLE;
            r_wb_wdata   <= '0;
            r_wb_whilo   <= WRITE_DISABLE;
            r_wb_hi      <= '0;
            r_wb_lo      <= '0;
            r_wb_valid   <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            case (w_act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    r_wb_wd    <= '0;
                    r_wb_wreg  <= WRITE_DISABLE;
                    r_wb_wdata <= '0;
                    r_wb_whilo <= WRITE_DISABLE;
                    r_wb_hi    <= '0;
                    r_wb_lo    <= '0;
                    r_wb_valid <= 1'b0;
                end
                ACT_ADVANCE: begin
                    // Bubbles still carry their fields but never write.
                    r_wb_wd    <= mem_wd;
                    r_wb_wreg  <= mem_wreg & mem_valid;
                    r_wb_wdata <= mem_wdata;
                    r_wb_whilo <= mem_whilo & mem_valid;
                    r_wb_hi    <= mem_hi;
                    r_wb_lo    <= mem_lo;
                    r_wb_valid <= mem_valid;
                end
                default: begin
                    // ACT_HOLD: keep the WB slot as is.
                end
            endcase
            if (w_retire)
                r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    mem_wb_hilo_hilo_reg #(
        .DATA_W (DATA_W)
    ) u_hilo_reg (
        .i_clk (clk),
        .i_rst (rst),
        .i_we  (w_commit),
        .i_hi  (r_wb_hi),
        .i_lo  (r_wb_lo),
        .o_hi  (hi_o),
        .o_lo  (lo_o)
    );

`ifdef HILO_FWD_EN
    always_comb begin
        ex_hi = hi_o;
        ex_lo = lo_o;
        if (mem_whilo) begin
            ex_hi = mem_hi;
            ex_lo = mem_lo;
        end else if (r_wb_whilo) begin
            ex_hi = r_wb_hi;
            ex_lo = r_wb_lo;
        end
    end
`else
    assign ex_hi = hi_o;
    assign ex_lo = lo_o;
`endif

    assign wb_wd      = r_wb_wd;
    assign wb_wreg    = r_wb_wreg;
    assign wb_wdata   = r_wb_wdata;
    assign wb_whilo   = r_wb_whilo;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_hilo.sv
// tb_mem_wb_hilo
//   Directed vector table, hand-written forwarding / counter-wrap sequences and a
//   randomized run against a behavioural model of the MEM->WB / HI/LO rules.
//   Honours HILO_FWD_EN the same way the design does.
module tb_mem_wb_hilo;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_hilo #(
        .DATA_W    (32),
        .ADDR_W    (5),
        .STALL_W   (6),
        .STALL_IDX (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .mem_whilo  (mem_whilo),
        .mem_hi     (mem_hi),
        .mem_lo     (mem_lo),
        .stall      (stall),
        .flush      (flush),
        .wb_wd      (wb_wd),
        .wb_wreg    (wb_wreg),
        .wb_wdata   (wb_wdata),
        .wb_whilo   (wb_whilo),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .ex_hi      (ex_hi),
        .ex_lo      (ex_lo),
        .retire_cnt (retire_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [4:0] wd, input logic wr,
                         input logic [31:0] wdat, input logic wh, input logic [31:0] h,
                         input logic [31:0] l, input logic [5:0] st, input logic fl);
        rst = r; mem_valid = v; mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
        mem_whilo = wh; mem_hi = h; mem_lo = l; stall = st; flush = fl;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        valid;
    } slot_t;

    slot_t       m_wb;
    logic [31:0] m_hi, m_lo, m_cnt;

    task automatic model_edge();
        slot_t empty;
        empty = '{wd: 5'd0, wreg: 1'b0, wdata: 32'd0, whilo: 1'b0, hi: 32'd0, lo: 32'd0, valid: 1'b0};
        if (!rst) begin
            m_wb = empty; m_hi = 0; m_lo = 0; m_cnt = 0;
        end else begin
            // The instruction leaving WB commits and retires unless WB is stalled.
            if (!stall[5]) begin
                if (m_wb.whilo) begin m_hi = m_wb.hi; m_lo = m_wb.lo; end
                if (m_wb.valid) m_cnt = m_cnt + 1;
            end
            if (flush)
                m_wb = empty;
            else if (stall[4] && !stall[5])
                m_wb = empty;
            else if (!stall[4])
                m_wb = '{wd: mem_wd, wreg: mem_wreg && mem_valid, wdata: mem_wdata,
                         whilo: mem_whilo && mem_valid, hi: mem_hi, lo: mem_lo, valid: mem_valid};
        end
    endtask

    function automatic logic [63:0] model_ex();
`ifdef HILO_FWD_EN
        if (mem_whilo) return {mem_hi, mem_lo};
        if (m_wb.whilo) return {m_wb.hi, m_wb.lo};
`endif
        return {m_hi, m_lo};
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        r, v;
        logic [4:0]  wd;
        logic        wr;
        logic [31:0] wdat;
        logic        wh;
        logic [31:0] h, l;
        logic [5:0]  st;
        logic        fl;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic        e_whilo;
        logic [31:0] e_hi, e_lo, e_cnt;
    } vec_t;

    vec_t vt[12];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ex;
        //        r  v  wd  wr wdata   wh hi      lo      stall       fl | wd  wr wdata  wh hi      lo      cnt
        vt[0]  = '{0, 1, 7,  1, 32'hDEAD, 1, 9,      8,      6'b000000, 0,  0, 0, 0,     0, 0,      0,      0};
        vt[1]  = '{0, 1, 7,  1, 32'hDEAD, 1, 9,      8,      6'b000000, 0,  0, 0, 0,     0, 0,      0,      0};
        vt[2]  = '{1, 1, 3,  1, 32'h11,   1, 32'h1234, 32'h5678, 6'b000000, 0,  3, 1, 32'h11, 1, 0,      0,      0};
        vt[3]  = '{1, 1, 5,  1, 32'h22,   0, 0,      0,      6'b000000, 0,  5, 1, 32'h22, 0, 32'h1234, 32'h5678, 1};
        vt[4]  = '{1, 1, 6,  1, 32'h33,   1, 32'hAA, 32'hBB, 6'b010000, 0,  0, 0, 0,     0, 32'h1234, 32'h5678, 2};
        vt[5]  = '{1, 1, 8,  1, 32'h44,   1, 32'hAA, 32'hBB, 6'b000000, 0,  8, 1, 32'h44, 1, 32'h1234, 32'h5678, 2};
        vt[6]  = '{1, 1, 9,  1, 32'h55,   0, 0,      0,      6'b110000, 0,  8, 1, 32'h44, 1, 32'h1234, 32'h5678, 2};
        vt[7]  = '{1, 1, 9,  1, 32'h55,   0, 0,      0,      6'b110000, 0,  8, 1, 32'h44, 1, 32'h1234, 32'h5678, 2};
        vt[8]  = '{1, 1, 10, 1, 32'h77,   1, 5,      5,      6'b000000, 1,  0, 0, 0,     0, 32'hAA, 32'hBB, 3};
        vt[9]  = '{1, 0, 12, 1, 32'h66,   1, 1,      2,      6'b000000, 0,  12, 0, 32'h66, 0, 32'hAA, 32'hBB, 3};
        vt[10] = '{1, 1, 0,  0, 0,        0, 0,      0,      6'b000000, 0,  0, 0, 0,     0, 32'hAA, 32'hBB, 3};
        vt[11] = '{1, 1, 0,  0, 0,        0, 0,      0,      6'b000000, 0,  0, 0, 0,     0, 32'hAA, 32'hBB, 4};

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].r, vt[i].v, vt[i].wd, vt[i].wr, vt[i].wdat, vt[i].wh,
                  vt[i].h, vt[i].l, vt[i].st, vt[i].fl);
            @(posedge clk); #1;
            chk($sformatf("vec%0d wb_wd", i),      {27'd0, wb_wd}, {27'd0, vt[i].e_wd});
            chk($sformatf("vec%0d wb_wreg", i),    {31'd0, wb_wreg}, {31'd0, vt[i].e_wreg});
            chk($sformatf("vec%0d wb_wdata", i),   wb_wdata, vt[i].e_wdata);
            chk($sformatf("vec%0d wb_whilo", i),   {31'd0, wb_whilo}, {31'd0, vt[i].e_whilo});
            chk($sformatf("vec%0d hi_o", i),       hi_o, vt[i].e_hi);
            chk($sformatf("vec%0d lo_o", i),       lo_o, vt[i].e_lo);
            chk($sformatf("vec%0d retire_cnt", i), retire_cnt, vt[i].e_cnt);
            @(negedge clk);
        end

        // ---- forwarding priority: hi_o=1, WB pending 2, MEM writing 3 ----
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); @(negedge clk);
        drive(1, 1, 1, 0, 0, 1, 32'h1, 32'h10, 6'b000000, 0);
        @(posedge clk); @(negedge clk);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 6'b000000, 0);
        @(posedge clk); @(negedge clk);
        drive(1, 1, 1, 0, 0, 1, 32'h2, 32'h20, 6'b000000, 0);
        @(posedge clk); @(negedge clk);
        chk("fwd base hi_o", hi_o, 32'h1);
        drive(1, 1, 1, 0, 0, 1, 32'h3, 32'h30, 6'b110000, 0);
        #1;
`ifdef HILO_FWD_EN
        chk("fwd mem ex_hi", ex_hi, 32'h3);
        chk("fwd mem ex_lo", ex_lo, 32'h30);
`else
        chk("fwd mem ex_hi", ex_hi, 32'h1);
        chk("fwd mem ex_lo", ex_lo, 32'h10);
`endif
        mem_whilo = 1'b0;
        #1;
`ifdef HILO_FWD_EN
        chk("fwd wb ex_hi", ex_hi, 32'h2);
        chk("fwd wb ex_lo", ex_lo, 32'h20);
`else
        chk("fwd wb ex_hi", ex_hi, 32'h1);
        chk("fwd wb ex_lo", ex_lo, 32'h10);
`endif
        @(posedge clk); #1;
        chk("held no commit hi_o", hi_o, 32'h1);
        @(negedge clk);

        // ---- retire counter wrap ----
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); @(negedge clk);
        drive(1, 1, 4, 1, 32'h9, 0, 0, 0, 6'b000000, 0);
        @(posedge clk); @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0);
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        chk("wrap preset retire_cnt", retire_cnt, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        chk("wrap retire_cnt", retire_cnt, 32'h0);
        @(negedge clk);

        // ---- randomized run against the model ----
        for (int n = 0; n < 400; n++) begin
            rst       = (n == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            mem_valid = ($urandom_range(0, 3) != 0);
            mem_wd    = 5'($urandom);
            mem_wreg  = 1'($urandom);
            mem_wdata = $urandom;
            mem_whilo = 1'($urandom);
            mem_hi    = $urandom;
            mem_lo    = $urandom;
            stall     = 6'($urandom);
            stall[4]  = ($urandom_range(0, 3) == 0);
            stall[5]  = stall[4] ? 1'($urandom) : ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            #1;
            if (n != 0) begin
                ex = model_ex();
                chk("rand ex_hi", ex_hi, ex[63:32]);
                chk("rand ex_lo", ex_lo, ex[31:0]);
            end
            model_edge();
            @(posedge clk); #1;
            chk("rand wb_wd",      {27'd0, wb_wd}, {27'd0, m_wb.wd});
            chk("rand wb_wreg",    {31'd0, wb_wreg}, {31'd0, m_wb.wreg});
            chk("rand wb_wdata",   wb_wdata, m_wb.wdata);
            chk("rand wb_whilo",   {31'd0, wb_whilo}, {31'd0, m_wb.whilo});
            chk("rand hi_o",       hi_o, m_hi);
            chk("rand lo_o",       lo_o, m_lo);
            chk("rand retire_cnt", retire_cnt, m_cnt);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
